// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one UART transmitter between two valid/ready byte producers.
//   Round-robin arbitration picks a requester while idle, then a one-cycle
//   start pulse is issued with the granted byte. Further starts are held off
//   for FRAME_BITS * B cycles (B = latched baud divisor, 0 treated as 1)
//   plus GAP_CYCLES idle cycles.
//
// Ports
//   CLOCK_50    in   system clock, rising edge
//   RESET       in   asynchronous, active-high reset
//   baud_rate   in   [19:0] clock cycles per UART bit, latched on start
//   req0_valid  in   requester 0 has a byte
//   req0_data   in   [7:0] requester 0 byte
//   req0_ready  out  requester 0 byte accepted this cycle (combinational)
//   req1_valid  in   requester 1 has a byte
//   req1_data   in   [7:0] requester 1 byte
//   req1_ready  out  requester 1 byte accepted this cycle (combinational)
//   tx_data     out  [7:0] byte for the transmitter, registered
//   start_tx    out  one-cycle start pulse, registered
//   tx_busy     out  frame or gap in progress, registered
//   grant_id    out  most recently granted requester, registered
module uart_tx_scheduler #(
    parameter int FRAME_BITS = 10,
    parameter int GAP_CYCLES = 0
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [19:0] baud_rate,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic [7:0]  tx_data,
    output logic        start_tx,
    output logic        tx_busy,
    output logic        grant_id
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_FRAME = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);
    localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam bit         HAS_GAP  = (GAP_CYCLES > 0);

    logic [1:0]  state_q, state_d;
    logic        ptr_q,   ptr_d;
    logic [7:0]  data_q,  data_d;
    logic        gid_q,   gid_d;
    logic        start_q, start_d;
    logic        busy_q,  busy_d;
    logic [19:0] baud_q,  baud_d;
    logic [19:0] cyc_q,   cyc_d;
    logic [3:0]  bit_q,   bit_d;
    logic [7:0]  gap_q,   gap_d;

    logic        any_valid;
    logic        grant_sel;
    logic        can_grant;
    logic [19:0] baud_eff;

    assign any_valid = req0_valid | req1_valid;
    // 1 selects requester 1; the pointer only matters when both are asking.
    assign grant_sel = (req0_valid & req1_valid) ? ptr_q : req1_valid;
    // RESET gates ready so a pending request is never acknowledged while
    // the state is being forced back to idle.
    assign can_grant = (state_q == S_IDLE) && !RESET && any_valid;
    assign req0_ready = can_grant && !grant_sel;
    assign req1_ready = can_grant &&  grant_sel;

    assign baud_eff = (baud_rate == 20'd0) ? 20'd1 : baud_rate;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        gid_d   = gid_q;
        baud_d  = baud_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    state_d = S_START;
                    data_d  = grant_sel ? req1_data : req0_data;
                    gid_d   = grant_sel;
                    ptr_d   = ~grant_sel;
                end
            end
            S_START: begin
                baud_d  = baud_eff;
                bit_d   = BIT_LAST;
                cyc_d   = baud_eff - 20'd1;
                state_d = S_FRAME;
            end
            S_FRAME: begin
                if (cyc_q != 20'd0) begin
                    cyc_d = cyc_q - 20'd1;
                end else if (bit_q != 4'd0) begin
                    cyc_d = baud_q - 20'd1;
                    bit_d = bit_q - 4'd1;
                end else if (HAS_GAP) begin
                    gap_d   = GAP_LAST;
                    state_d = S_GAP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q != 8'd0) begin
                    gap_d = gap_q - 8'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered images of the next state, so they line up
        // with the state they describe.
        start_d = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            data_q  <= 8'h00;
            gid_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            baud_q  <= '0;
            cyc_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            baud_q  <= baud_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
        end
    end

    assign tx_data  = data_q;
    assign start_tx = start_q;
    assign tx_busy  = busy_q;
    assign grant_id = gid_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler (FRAME_BITS=10, GAP_CYCLES=2).
// The reference model works purely on cycle arithmetic: a grant at cycle N
// means start at N+1 and idle again at N+1+FRAME_BITS*B+GAP+1.
module tb_uart_tx_scheduler;

    localparam int FB  = 10;
    localparam int GAP = 2;

    logic        CLOCK_50 = 1'b0;
    logic        RESET = 1'b1;
    logic [19:0] baud_rate = 20'd1;
    logic        req0_valid = 1'b0;
    logic [7:0]  req0_data = 8'h00;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [7:0]  req1_data = 8'h00;
    logic        req1_ready;
    logic [7:0]  tx_data;
    logic        start_tx;
    logic        tx_busy;
    logic        grant_id;

    uart_tx_scheduler #(.FRAME_BITS(FB), .GAP_CYCLES(GAP)) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .baud_rate (baud_rate),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .tx_data   (tx_data),
        .start_tx  (start_tx),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    // model state
    longint     cyc = 0;
    longint     s_cyc = -10;
    longint     idle_at = 0;
    logic [7:0] m_data = 8'h00, pend_data = 8'h00;
    logic       m_gid = 1'b0, pend_gid = 1'b0, m_ptr = 1'b0;
    // observations used by the driver and by literal checks
    logic       acc0 = 1'b0, acc1 = 1'b0;
    int         run = 0, last_busy_len = 0, nstarts = 0;
    longint     last_start = 0, last_spacing = 0;
    logic [7:0] log_data [0:2047];
    logic       log_gid  [0:2047];

    initial begin
        longint b;
        logic   m_idle, e0, e1;
        forever begin
            @(negedge CLOCK_50);
            cyc++;
            if (RESET) begin
                s_cyc = -10; idle_at = 0;
                m_data = 8'h00; m_gid = 1'b0; m_ptr = 1'b0;
                chk("rst_start", start_tx, 0);
                chk("rst_busy", tx_busy, 0);
                chk("rst_data", tx_data, 8'h00);
                chk("rst_gid", grant_id, 0);
                chk("rst_rdy0", req0_ready, 0);
                chk("rst_rdy1", req1_ready, 0);
                acc0 = 1'b0; acc1 = 1'b0; run = 0;
            end else begin
                if (cyc == s_cyc) begin
                    b = (baud_rate == 20'd0) ? 1 : longint'(baud_rate);
                    idle_at = cyc + FB * b + GAP + 1;
                    m_data = pend_data;
                    m_gid  = pend_gid;
                end
                chk("start_tx", start_tx, (cyc == s_cyc));
                chk("tx_busy", tx_busy, (cyc >= s_cyc && cyc < idle_at));
                chk("tx_data", tx_data, m_data);
                chk("grant_id", grant_id, m_gid);
                m_idle = (cyc >= idle_at);
                e0 = m_idle && req0_valid && (!req1_valid || m_ptr == 1'b0);
                e1 = m_idle && req1_valid && (!req0_valid || m_ptr == 1'b1);
                chk("req0_ready", req0_ready, e0);
                chk("req1_ready", req1_ready, e1);
                if (e0 || e1) begin
                    pend_data = e0 ? req0_data : req1_data;
                    pend_gid  = e1;
                    m_ptr     = e0;
                    s_cyc     = cyc + 1;
                    idle_at   = cyc + 2;
                end
                acc0 = req0_ready;
                acc1 = req1_ready;
                if (start_tx) begin
                    if (nstarts < 2048) begin
                        log_data[nstarts] = tx_data;
                        log_gid[nstarts]  = grant_id;
                    end
                    nstarts++;
                    last_spacing = cyc - last_start;
                    last_start   = cyc;
                end
                if (tx_busy) run++;
                else if (run > 0) begin
                    last_busy_len = run;
                    run = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send(input int k, input logic [7:0] d);
        bit done;
        done = 0;
        if (k == 0) begin req0_valid = 1'b1; req0_data = d; end
        else        begin req1_valid = 1'b1; req1_data = d; end
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            if (k == 0 && acc0) begin req0_valid = 1'b0; done = 1; end
            if (k == 1 && acc1) begin req1_valid = 1'b0; done = 1; end
        end
        if (!done) begin
            chk("send_timeout", 1, 0);
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            step();
            if (!tx_busy) done = 1;
        end
        if (!done) chk("idle_timeout", 1, 0);
        step();
    endtask

    initial begin
        int n0, grants, rst_left;
        logic [7:0] want_d [0:3];
        logic       want_g [0:3];
        want_d[0] = 8'h11; want_d[1] = 8'h22; want_d[2] = 8'h11; want_d[3] = 8'h22;
        want_g[0] = 1'b0;  want_g[1] = 1'b1;  want_g[2] = 1'b0;  want_g[3] = 1'b1;

        // reset held for three cycles with no requests
        repeat (3) step();
        RESET = 1'b0;
        repeat (3) step();

        // contention: both requesters hold valid continuously
        n0 = nstarts;
        req0_valid = 1'b1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_data = 8'h22;
        grants = 0;
        for (int i = 0; i < 400 && grants < 4; i++) begin
            step();
            grants += int'(acc0) + int'(acc1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("contention_grants", grants, 4);
        wait_idle();
        chk("contention_starts", nstarts - n0, 4);
        for (int i = 0; i < 4; i++) begin
            chk("contention_gid", log_gid[n0 + i], want_g[i]);
            chk("contention_data", log_data[n0 + i], want_d[i]);
        end
        chk("contention_spacing", last_spacing, 14);

        // single request, baud 1
        n0 = nstarts;
        send(0, 8'hA5);
        wait_idle();
        chk("single_busy_len", last_busy_len, 13);
        chk("single_data", log_data[n0], 8'hA5);

        // baud 4
        baud_rate = 20'd4;
        send(1, 8'h5C);
        wait_idle();
        chk("baud4_busy_len", last_busy_len, 43);

        // baud 0 behaves as baud 1
        baud_rate = 20'd0;
        send(0, 8'h3C);
        wait_idle();
        chk("baud0_busy_len", last_busy_len, 13);

        // baud change mid-frame
        baud_rate = 20'd4;
        send(1, 8'hC3);
        repeat (10) step();
        baud_rate = 20'd7;
        wait_idle();
        chk("baud_change_busy_len", last_busy_len, 43);

        // reset mid-frame with requester 1 pending
        baud_rate = 20'd4;
        send(0, 8'h5A);
        req1_valid = 1'b1; req1_data = 8'h77;
        repeat (20) step();
        RESET = 1'b1;
        step();
        step();
        n0 = nstarts;
        RESET = 1'b0;
        step();
        chk("post_reset_ack1", acc1, 1);
        req1_valid = 1'b0;
        step();
        chk("post_reset_starts", nstarts - n0, 1);
        chk("post_reset_gid", log_gid[n0], 1);
        chk("post_reset_data", log_data[n0], 8'h77);
        wait_idle();

        // randomized traffic with occasional resets
        baud_rate = 20'd1;
        rst_left = 0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) RESET = 1'b0;
            end else if ($urandom_range(599) == 0) begin
                RESET = 1'b1;
                rst_left = int'($urandom_range(2, 1));
            end
            if (req0_valid && acc0) begin
                req0_valid = ($urandom_range(1) == 1);
                req0_data  = 8'($urandom);
            end else if (!req0_valid && $urandom_range(9) < 3) begin
                req0_valid = 1'b1;
                req0_data  = 8'($urandom);
            end
            if (req1_valid && acc1) begin
                req1_valid = ($urandom_range(1) == 1);
                req1_data  = 8'($urandom);
            end else if (!req1_valid && $urandom_range(9) < 3) begin
                req1_valid = 1'b1;
                req1_data  = 8'($urandom);
            end
            if ($urandom_range(9) == 0) baud_rate = 20'($urandom_range(5));
        end
        RESET = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
